// File: rtl/wimpfi_pkg.sv
// Shared WimpFi MAC types and constants: controller state encoding, LFSR taps,
// default channel timing and the random-draw helpers.
package wimpfi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DIFS      = 3'd1,
        BACKOFF   = 3'd2,
        SEND      = 3'd3,
        WAIT_XMIT = 3'd4,
        WAIT_ACK  = 3'd5
    } csma_state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_CLK_FREQ         = 100_000_000;
    localparam int DEF_BIT_RATE         = 50_000;
    localparam int DEF_DIFS_BITS        = 80;
    localparam int DEF_SLOT_BITS        = 8;
    localparam int DEF_ACK_TIMEOUT_BITS = 256;
    localparam int DEF_MAX_RETRY        = 5;
    localparam int DEF_CW_MIN_EXP       = 2;
    localparam int DEF_CW_MAX_EXP       = 7;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [7:0] draw_slots(input logic [7:0] rnd,
                                               input logic [7:0] mac,
                                               input logic [2:0] cw_exp);
        logic [8:0] span;
        span = (9'd1 << cw_exp) - 9'd1;
        return (rnd ^ mac) & span[7:0];
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks; shared by
// the transmit-side controller and the receiver.
module bit_tick_gen #(
    parameter int DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          tick_d, tick_q;

    // Wrap the counter and flag the wrap cycle.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + ONE;
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/csma_backoff_ctl.sv
// CSMA/CA access controller: DIFS deferral, random slot backoff, ACK timeout and
// binary-exponential retry in front of the WimpFi transmitter.
module csma_backoff_ctl
    import wimpfi_pkg::*;
#(
    parameter int          CLK_FREQ         = DEF_CLK_FREQ,
    parameter int          BIT_RATE         = DEF_BIT_RATE,
    parameter int          DIFS_BITS        = DEF_DIFS_BITS,
    parameter int          SLOT_BITS        = DEF_SLOT_BITS,
    parameter int          ACK_TIMEOUT_BITS = DEF_ACK_TIMEOUT_BITS,
    parameter int          MAX_RETRY        = DEF_MAX_RETRY,
    parameter int          CW_MIN_EXP       = DEF_CW_MIN_EXP,
    parameter int          CW_MAX_EXP       = DEF_CW_MAX_EXP,
    parameter logic [15:0] SEED             = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_rdy,
    input  logic       ack_required,
    input  logic [7:0] mac,
    input  logic       cardet,
    input  logic       xbusy,
    input  logic       ack_received,
    output logic       xmit_go,
    output logic       ack_rcv_clr,
    output logic       backoff,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] retry_cnt
);
    localparam int            DW        = $clog2(DIFS_BITS + 1);
    localparam int            SW        = $clog2(SLOT_BITS + 1);
    localparam int            AW        = $clog2(ACK_TIMEOUT_BITS + 1);
    localparam logic [DW-1:0] DIFS_LAST = DW'(DIFS_BITS);
    localparam logic [DW-1:0] DIFS_ONE  = DW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_BITS);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT_BITS);
    localparam logic [AW-1:0] ACK_ONE   = AW'(1);
    localparam logic [2:0]    CW_MIN    = 3'(CW_MIN_EXP);
    localparam logic [2:0]    CW_MAX    = 3'(CW_MAX_EXP);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    csma_state_t   state_d, state_q;
    logic [DW-1:0] difs_cnt_d, difs_cnt_q;
    logic [SW-1:0] slot_cnt_d, slot_cnt_q;
    logic [AW-1:0] ack_tmr_d, ack_tmr_q;
    logic [7:0]    slots_d, slots_q;
    logic [2:0]    cw_exp_d, cw_exp_q;
    logic [3:0]    retry_d, retry_q;
    logic [15:0]   lfsr_d, lfsr_q;
    logic          ack_req_d, ack_req_q, seen_d, seen_q;
    logic          xmit_go_d, xmit_go_q, ack_rcv_clr_d, ack_rcv_clr_q;
    logic          backoff_d, backoff_q, busy_d, busy_q;
    logic          done_d, done_q, fail_d, fail_q;

    logic          tick_s;
    logic [DW-1:0] difs_inc_s;
    logic [SW-1:0] slot_inc_s;
    logic [AW-1:0] ack_inc_s;
    logic [2:0]    cw_next_s;

    bit_tick_gen #(.DIV(CLK_FREQ / BIT_RATE)) u_tick (
        .clk   (clk),
        .rst_n (rst),
        .tick  (tick_s)
    );

    assign difs_inc_s = difs_cnt_q + DIFS_ONE;
    assign slot_inc_s = slot_cnt_q + SLOT_ONE;
    assign ack_inc_s  = ack_tmr_q + ACK_ONE;
    assign cw_next_s  = (cw_exp_q >= CW_MAX) ? CW_MAX : cw_exp_q + 3'd1;

    // Next-state and datapath updates; outputs are derived from the next state.
    always_comb begin
        state_d       = state_q;
        difs_cnt_d    = difs_cnt_q;
        slot_cnt_d    = slot_cnt_q;
        ack_tmr_d     = ack_tmr_q;
        slots_d       = slots_q;
        cw_exp_d      = cw_exp_q;
        retry_d       = retry_q;
        ack_req_d     = ack_req_q;
        seen_d        = seen_q;
        lfsr_d        = lfsr_step(lfsr_q);
        ack_rcv_clr_d = 1'b0;
        done_d        = 1'b0;
        fail_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_rdy) begin
                    ack_req_d  = ack_required;
                    retry_d    = 4'd0;
                    cw_exp_d   = CW_MIN;
                    slots_d    = draw_slots(lfsr_q[7:0], mac, CW_MIN);
                    difs_cnt_d = '0;
                    slot_cnt_d = '0;
                    state_d    = DIFS;
                end else begin
                    state_d = IDLE;
                end
            end
            DIFS: begin
                if (cardet) begin
                    difs_cnt_d = '0;
                end else if (tick_s) begin
                    if (difs_inc_s == DIFS_LAST) begin
                        difs_cnt_d = '0;
                        state_d    = (slots_q == 8'd0) ? SEND : BACKOFF;
                    end else begin
                        difs_cnt_d = difs_inc_s;
                    end
                end else begin
                    difs_cnt_d = difs_cnt_q;
                end
            end
            BACKOFF: begin
                // Carrier freezes the remaining slot count and re-defers.
                if (cardet) begin
                    slot_cnt_d = '0;
                    difs_cnt_d = '0;
                    state_d    = DIFS;
                end else if (tick_s) begin
                    if (slot_inc_s == SLOT_LAST) begin
                        slot_cnt_d = '0;
                        slots_d    = slots_q - 8'd1;
                        state_d    = (slots_q == 8'd1) ? SEND : BACKOFF;
                    end else begin
                        slot_cnt_d = slot_inc_s;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q;
                end
            end
            SEND: begin
                seen_d  = 1'b0;
                state_d = WAIT_XMIT;
            end
            WAIT_XMIT: begin
                if (xbusy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (ack_req_q) begin
                        ack_tmr_d = '0;
                        state_d   = WAIT_ACK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    seen_d = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (ack_received) begin
                    ack_rcv_clr_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else if (tick_s) begin
                    if (ack_inc_s == ACK_LAST) begin
                        ack_tmr_d = '0;
                        if (retry_q >= RETRY_MAX) begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            retry_d    = retry_q + 4'd1;
                            cw_exp_d   = cw_next_s;
                            slots_d    = draw_slots(lfsr_q[7:0], mac, cw_next_s);
                            difs_cnt_d = '0;
                            slot_cnt_d = '0;
                            state_d    = DIFS;
                        end
                    end else begin
                        ack_tmr_d = ack_inc_s;
                    end
                end else begin
                    ack_tmr_d = ack_tmr_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        xmit_go_d = (state_d == SEND);
        backoff_d = (state_d == DIFS) || (state_d == BACKOFF);
        busy_d    = (state_d != IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            difs_cnt_q    <= '0;
            slot_cnt_q    <= '0;
            ack_tmr_q     <= '0;
            slots_q       <= 8'd0;
            cw_exp_q      <= CW_MIN;
            retry_q       <= 4'd0;
            ack_req_q     <= 1'b0;
            seen_q        <= 1'b0;
            lfsr_q        <= SEED;
            xmit_go_q     <= 1'b0;
            ack_rcv_clr_q <= 1'b0;
            backoff_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            difs_cnt_q    <= difs_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            ack_tmr_q     <= ack_tmr_d;
            slots_q       <= slots_d;
            cw_exp_q      <= cw_exp_d;
            retry_q       <= retry_d;
            ack_req_q     <= ack_req_d;
            seen_q        <= seen_d;
            lfsr_q        <= lfsr_d;
            xmit_go_q     <= xmit_go_d;
            ack_rcv_clr_q <= ack_rcv_clr_d;
            backoff_q     <= backoff_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
        end
    end

    assign xmit_go     = xmit_go_q;
    assign ack_rcv_clr = ack_rcv_clr_q;
    assign backoff     = backoff_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_csma_backoff_ctl.sv
// Directed bench for csma_backoff_ctl: bit tick every 10 clocks, DIFS=4, SLOT=2,
// ACK timeout 16 ticks, MAX_RETRY=2. Second instance uses CW_MIN_EXP=2.
module tb_csma_backoff_ctl;

    localparam int TDIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_rdy, frame_rdy3, ack_required, cardet, xbusy, ack_received;
    logic [7:0] mac;
    logic       xmit_go, ack_rcv_clr, backoff, busy, done, fail;
    logic [3:0] retry_cnt;
    logic       xmit_go3, ack_rcv_clr3, backoff3, busy3, done3, fail3;
    logic [3:0] retry_cnt3;
    logic [9:0] outs, outs3;

    int          cyc;
    logic [15:0] lfsr_m;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    csma_backoff_ctl #(
        .CLK_FREQ(1000), .BIT_RATE(100), .DIFS_BITS(4), .SLOT_BITS(2),
        .ACK_TIMEOUT_BITS(16), .MAX_RETRY(2), .CW_MIN_EXP(0), .CW_MAX_EXP(7),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .frame_rdy(frame_rdy), .ack_required(ack_required),
        .mac(mac), .cardet(cardet), .xbusy(xbusy), .ack_received(ack_received),
        .xmit_go(xmit_go), .ack_rcv_clr(ack_rcv_clr), .backoff(backoff), .busy(busy),
        .done(done), .fail(fail), .retry_cnt(retry_cnt)
    );

    csma_backoff_ctl #(
        .CLK_FREQ(1000), .BIT_RATE(100), .DIFS_BITS(4), .SLOT_BITS(2),
        .ACK_TIMEOUT_BITS(16), .MAX_RETRY(2), .CW_MIN_EXP(2), .CW_MAX_EXP(7),
        .SEED(16'hACE1)
    ) dut3 (
        .clk(clk), .rst(rst), .frame_rdy(frame_rdy3), .ack_required(ack_required),
        .mac(mac), .cardet(cardet), .xbusy(xbusy), .ack_received(ack_received),
        .xmit_go(xmit_go3), .ack_rcv_clr(ack_rcv_clr3), .backoff(backoff3), .busy(busy3),
        .done(done3), .fail(fail3), .retry_cnt(retry_cnt3)
    );

    assign outs  = {xmit_go, ack_rcv_clr, backoff, busy, done, fail, retry_cnt};
    assign outs3 = {xmit_go3, ack_rcv_clr3, backoff3, busy3, done3, fail3, retry_cnt3};

    // Edge count since reset release, plus reference LFSR per the channel polynomial.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc    <= 0;
            lfsr_m <= 16'hACE1;
        end else begin
            cyc    <= cyc + 1;
            lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
        end
    end

    // The controller consumes a bit tick on edges 11, 21, 31, ... after reset release.
    function automatic int next_tick_edge(input int after, input int k);
        int n;
        n = after + 1;
        while ((n % TDIV) != 1 || n < TDIV + 1) n++;
        return n + TDIV * (k - 1);
    endfunction

    task automatic wait_go(input bit sel, input int budget, output int at, output int bo_low);
        at = -1;
        bo_low = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((sel ? xmit_go3 : xmit_go) === 1'b1) begin
                at = cyc;
                break;
            end
            if ((sel ? backoff3 : backoff) !== 1'b1) bo_low++;
        end
    endtask

    task automatic drive_xbusy(input int n, output int x_edge);
        xbusy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        xbusy = 1'b0;
        x_edge = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        frame_rdy = 1'b1;
        frame_rdy3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (outs !== 10'd0) begin n_fail++; $display("FAIL reset_outs: got %b want 0", outs); end
        n_checks++;
        if (outs3 !== 10'd0) begin n_fail++; $display("FAIL reset_outs3: got %b want 0", outs3); end
        frame_rdy = 1'b0;
        frame_rdy3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, backoff} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {busy, backoff}); end
    endtask

    task automatic test_fast_path();
        int e, g, bl, x;
        ack_required = 1'b0;
        frame_rdy = 1'b1;
        e = cyc;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        n_checks++;
        if ({backoff, busy} !== 2'b11) begin n_fail++; $display("FAIL fast_difs_flags: got %b want 11", {backoff, busy}); end
        wait_go(1'b0, 200, g, bl);
        n_checks++;
        if (g !== next_tick_edge(e + 1, 4)) begin n_fail++; $display("FAIL fast_go_edge: got %0d want %0d", g, next_tick_edge(e + 1, 4)); end
        xbusy = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (xmit_go !== 1'b0) begin n_fail++; $display("FAIL fast_go_width: got %b want 0", xmit_go); end
        drive_xbusy(19, x);
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL fast_done: got %b want 1", done); end
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL fast_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic test_carrier_difs();
        int e, t3, g, bl, x;
        ack_required = 1'b0;
        frame_rdy = 1'b1;
        e = cyc;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        t3 = next_tick_edge(e + 1, 3);
        while (cyc < t3) begin @(posedge clk); #1; end
        cardet = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cardet = 1'b0;
        n_checks++;
        if (backoff !== 1'b1) begin n_fail++; $display("FAIL carrier_backoff: got %b want 1", backoff); end
        wait_go(1'b0, 200, g, bl);
        n_checks++;
        if (g !== t3 + 40) begin n_fail++; $display("FAIL carrier_go_edge: got %0d want %0d", g, t3 + 40); end
        n_checks++;
        if (bl !== 0) begin n_fail++; $display("FAIL carrier_backoff_gap: got %0d want 0", bl); end
        drive_xbusy(3, x);
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL carrier_done: got %b want 1", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_frozen_backoff();
        int e, t6, g, bl, x;
        ack_required = 1'b0;
        mac = {6'd0, ~lfsr_m[1:0]};
        frame_rdy3 = 1'b1;
        e = cyc;
        @(posedge clk); #1;
        frame_rdy3 = 1'b0;
        mac = 8'd0;
        t6 = next_tick_edge(e + 1, 6);
        while (cyc < t6) begin @(posedge clk); #1; end
        n_checks++;
        if ({backoff3, busy3, xmit_go3} !== 3'b110) begin n_fail++; $display("FAIL frozen_in_backoff: got %b want 110", {backoff3, busy3, xmit_go3}); end
        cardet = 1'b1;
        @(posedge clk); #1;
        cardet = 1'b0;
        wait_go(1'b1, 300, g, bl);
        n_checks++;
        if (g !== next_tick_edge(t6 + 1, 8)) begin n_fail++; $display("FAIL frozen_go_edge: got %0d want %0d", g, next_tick_edge(t6 + 1, 8)); end
        n_checks++;
        if (bl !== 0) begin n_fail++; $display("FAIL frozen_backoff_gap: got %0d want 0", bl); end
        drive_xbusy(3, x);
        @(posedge clk); #1;
        n_checks++;
        if (done3 !== 1'b1) begin n_fail++; $display("FAIL frozen_done: got %b want 1", done3); end
        @(posedge clk); #1;
    endtask

    task automatic test_ack_success();
        int g, bl, x;
        ack_required = 1'b1;
        frame_rdy = 1'b1;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        ack_required = 1'b0;
        wait_go(1'b0, 200, g, bl);
        drive_xbusy(3, x);
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, ack_rcv_clr} !== 3'b100) begin n_fail++; $display("FAIL ack_waiting: got %b want 100", {busy, done, ack_rcv_clr}); end
        ack_received = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ack_rcv_clr, done} !== 2'b11) begin n_fail++; $display("FAIL ack_pulses: got %b want 11", {ack_rcv_clr, done}); end
        n_checks++;
        if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL ack_retry: got %0d want 0", retry_cnt); end
        ack_received = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({ack_rcv_clr, done, busy} !== 3'b000) begin n_fail++; $display("FAIL ack_idle: got %b want 000", {ack_rcv_clr, done, busy}); end
    endtask

    task automatic test_retry_exhaust();
        int e, gos, dones, fails, fail_edge, fail_retry, exp_go, xb, r_edge, s;
        ack_required = 1'b1;
        mac = 8'd0;
        frame_rdy = 1'b1;
        e = cyc;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        gos = 0; dones = 0; fails = 0; fail_edge = -1; fail_retry = -1;
        xb = 0; r_edge = -1;
        exp_go = next_tick_edge(e + 1, 4);
        for (int i = 0; i < 3000 && fails == 0; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
            if (fail === 1'b1) begin
                fails++;
                fail_edge = cyc;
                fail_retry = int'(retry_cnt);
            end
            if (xmit_go === 1'b1) begin
                n_checks++;
                if (cyc !== exp_go) begin n_fail++; $display("FAIL retry_go_edge%0d: got %0d want %0d", gos, cyc, exp_go); end
                n_checks++;
                if (retry_cnt !== 4'(gos)) begin n_fail++; $display("FAIL retry_cnt_at_go%0d: got %0d want %0d", gos, retry_cnt, gos); end
                gos++;
                xbusy = 1'b1;
                xb = 3;
            end else if (xb > 0) begin
                xb--;
                if (xb == 0) begin
                    xbusy = 1'b0;
                    r_edge = next_tick_edge(cyc + 1, 16);
                end
            end
            if (cyc == r_edge - 1) begin
                s = int'(lfsr_m[7:0]) & ((1 << gos) - 1);
                exp_go = (s == 0) ? next_tick_edge(r_edge, 4) : next_tick_edge(r_edge, 4 + 2 * s);
            end
        end
        ack_required = 1'b0;
        n_checks++;
        if (gos !== 3) begin n_fail++; $display("FAIL retry_go_count: got %0d want 3", gos); end
        n_checks++;
        if ({fails, dones} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL retry_fail_done: got fail=%0d done=%0d want 1 0", fails, dones); end
        n_checks++;
        if (fail_edge !== r_edge) begin n_fail++; $display("FAIL retry_fail_edge: got %0d want %0d", fail_edge, r_edge); end
        n_checks++;
        if (fail_retry !== 2) begin n_fail++; $display("FAIL retry_cnt_at_fail: got %0d want 2", fail_retry); end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, fail} !== 2'b00) begin n_fail++; $display("FAIL retry_idle: got %b want 00", {busy, fail}); end
    endtask

    task automatic test_async_reset();
        int e, g, bl, x;
        ack_required = 1'b1;
        frame_rdy = 1'b1;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        ack_required = 1'b0;
        wait_go(1'b0, 200, g, bl);
        drive_xbusy(3, x);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== 10'd0) begin n_fail++; $display("FAIL areset_outs: got %b want 0", outs); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        frame_rdy = 1'b1;
        e = cyc;
        @(posedge clk); #1;
        frame_rdy = 1'b0;
        n_checks++;
        if ({backoff, busy, done, fail} !== 4'b1100) begin n_fail++; $display("FAIL areset_restart: got %b want 1100", {backoff, busy, done, fail}); end
        wait_go(1'b0, 200, g, bl);
        n_checks++;
        if (g !== next_tick_edge(e + 1, 4)) begin n_fail++; $display("FAIL areset_go_edge: got %0d want %0d", g, next_tick_edge(e + 1, 4)); end
        drive_xbusy(3, x);
        @(posedge clk); #1;
        n_checks++;
        if ({done, fail} !== 2'b10) begin n_fail++; $display("FAIL areset_done: got %b want 10", {done, fail}); end
    endtask

    initial begin
        frame_rdy = 1'b0;
        frame_rdy3 = 1'b0;
        ack_required = 1'b0;
        mac = 8'd0;
        cardet = 1'b0;
        xbusy = 1'b0;
        ack_received = 1'b0;
        test_reset();
        test_fast_path();
        test_carrier_difs();
        test_frozen_backoff();
        test_ack_success();
        test_retry_exhaust();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
